// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : pc_seq_pkg
// Brief  : Shared state encoding and next_sel codes for the PC sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_t;

    // Encodings shared with PC_deco
    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_JMP  = 2'b01;
    localparam logic [1:0] SEL_JREG = 2'b10;
    localparam logic [1:0] SEL_BR   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : pc_sequencer_if
// Brief  : Instruction-memory fetch handshake plus IF/ID valid strobe.
// Rev    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic            instr_valid;

    modport master (output imem_req, output imem_addr, output instr_valid, input imem_ready);
    modport slave  (input imem_req, input imem_addr, input instr_valid, output imem_ready);
endinterface
`default_nettype wire

// File: rtl/pc_target_mux.sv
`default_nettype none
// ============================================================================
// Module : pc_target_mux
// Brief  : Combinational next-PC select driven by the branch/jump decoder.
// Rev    : 1.0  initial release
// ============================================================================
module pc_target_mux
    import pc_seq_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [1:0]      next_sel,
    input  logic [PC_W-1:0] seq_pc,
    input  logic [PC_W-1:0] jump_target,
    input  logic [PC_W-1:0] jreg_target,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] target
);
    always_comb begin
        target = seq_pc;
        case (next_sel)
            SEL_JMP:  target = jump_target;
            SEL_JREG: target = jreg_target;
            SEL_BR:   target = branch_target;
            default:  target = seq_pc;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pc_sequencer
// Brief  : Program counter and instruction-fetch sequencer of the ASIP.
//          Optional PC_SEQ_PERF_EN adds redirect_cnt / stall_cnt outputs.
// Rev    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] PC_INC   = {{(PC_W-1){1'b0}}, 1'b1}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        next_sel,
    input  logic [PC_W-1:0]   jump_target,
    input  logic [PC_W-1:0]   jreg_target,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    pc_sequencer_if.master    imem,
    output logic [PC_W-1:0]   pc,
    output logic              flush,
    output logic              halted
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]       redirect_cnt,
    output logic [31:0]       stall_cnt
`endif
);
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] drain_addr_q, drain_addr_d;
    logic            halt_pend_q, halt_pend_d;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic            redirect;
    logic            req, valid, flush_d;

    assign pc_inc   = pc_q + PC_INC;
    assign redirect = (next_sel != SEL_SEQ);

    pc_target_mux #(.PC_W(PC_W)) u_mux (
        .next_sel      (next_sel),
        .seq_pc        (pc_inc),
        .jump_target   (jump_target),
        .jreg_target   (jreg_target),
        .branch_target (branch_target),
        .target        (target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            halt_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            halt_pend_q  <= halt_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        halt_pend_d  = halt_pend_q;
        req          = 1'b0;
        valid        = 1'b0;
        flush_d      = 1'b0;
        case (state_q)
            BOOT: begin
                if (redirect) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                    state_d = FETCH;
                end else if (halt) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A not-yet-accepted FETCH request may be dropped; only WAIT is committed
                if (redirect) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end else if (halt) begin
                    state_d = HALT;
                end else if (!stall) begin
                    req = 1'b1;
                    if (imem.imem_ready) begin
                        valid = 1'b1;
                        pc_d  = pc_inc;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (redirect) begin
                    pc_d        = target;
                    flush_d     = 1'b1;
                    halt_pend_d = 1'b0;
                    if (imem.imem_ready) begin
                        state_d = FETCH;
                    end else begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (halt) begin
                    if (imem.imem_ready) begin
                        state_d = HALT;
                    end else begin
                        drain_addr_d = pc_q;
                        halt_pend_d  = 1'b1;
                        state_d      = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    // Under stall the word is dropped and pc kept, so it is fetched again
                    state_d = FETCH;
                    if (!stall) begin
                        valid = 1'b1;
                        pc_d  = pc_inc;
                    end
                end
            end
            DRAIN: begin
                req = 1'b1;
                if (redirect) begin
                    pc_d        = target;
                    flush_d     = 1'b1;
                    halt_pend_d = 1'b0;
                end else if (halt) begin
                    halt_pend_d = 1'b1;
                end
                if (imem.imem_ready) begin
                    if (halt_pend_d) state_d = HALT;
                    else             state_d = FETCH;
                    halt_pend_d = 1'b0;
                end
            end
            HALT: begin
                if (resume) state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    assign imem.imem_req    = req;
    assign imem.imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign imem.instr_valid = valid;
    assign pc               = pc_q;
    assign flush            = flush_d;
    assign halted           = (state_q == HALT);

`ifdef PC_SEQ_PERF_EN
    logic [31:0] redirect_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (flush_d && (redirect_cnt_q != 32'hFFFF_FFFF))
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_sequencer
// Brief  : Directed self-checking bench for pc_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  next_sel = SEL_SEQ;
    logic [15:0] jump_target = '0, jreg_target = '0, branch_target = '0;
    logic        stall = 1'b0, halt = 1'b0, resume = 1'b0;
    logic [15:0] pc;
    logic        flush, halted;
    int          n_tests = 0;
    int          n_fail  = 0;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] redirect_cnt, stall_cnt;
`endif

    pc_sequencer_if #(.PC_W(16)) bus ();

    pc_sequencer #(.PC_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .next_sel      (next_sel),
        .jump_target   (jump_target),
        .jreg_target   (jreg_target),
        .branch_target (branch_target),
        .stall         (stall),
        .halt          (halt),
        .resume        (resume),
        .imem          (bus),
        .pc            (pc),
        .flush         (flush),
        .halted        (halted)
`ifdef PC_SEQ_PERF_EN
        ,
        .redirect_cnt  (redirect_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.imem_ready = 1'b1;
        mid();
        mid();
        n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 16'h0000); end
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", flush); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        tick();
        rst = 1'b0;
        mid();
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b expected 0", bus.imem_req); end
    endtask

    task automatic test_seq();
        for (int i = 0; i < 4; i++) begin
            tick();
            mid();
            n_tests++; if (bus.imem_addr !== 16'(i)) begin n_fail++; $display("FAIL seq_addr%0d: got %h expected %h", i, bus.imem_addr, 16'(i)); end
            n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b expected 1", i, bus.instr_valid); end
        end
    endtask

    task automatic test_branch();
        tick(); mid();
        tick();
        next_sel = SEL_BR; branch_target = 16'h0040;
        mid();
        n_tests++; if (pc !== 16'h0005) begin n_fail++; $display("FAIL br_pc: got %h expected %h", pc, 16'h0005); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b expected 1", flush); end
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b expected 0", bus.instr_valid); end
        tick();
        next_sel = SEL_SEQ;
        mid();
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_flush_end: got %b expected 0", flush); end
        n_tests++; if (bus.imem_addr !== 16'h0040) begin n_fail++; $display("FAIL br_addr: got %h expected %h", bus.imem_addr, 16'h0040); end
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL br_tgt_valid: got %b expected 1", bus.instr_valid); end
    endtask

    task automatic test_wait_drain();
        tick();
        next_sel = SEL_JMP; jump_target = 16'h0007;
        mid();
        tick();
        next_sel = SEL_SEQ; bus.imem_ready = 1'b0;
        mid();
        n_tests++; if (bus.imem_addr !== 16'h0007 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wd_fetch: got addr %h req %b expected 0007 1", bus.imem_addr, bus.imem_req); end
        tick();
        next_sel = SEL_JMP; jump_target = 16'h0100;
        mid();
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL wd_flush: got %b expected 1", flush); end
        n_tests++; if (bus.imem_addr !== 16'h0007 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wd_wait_addr: got addr %h req %b expected 0007 1", bus.imem_addr, bus.imem_req); end
        tick();
        next_sel = SEL_SEQ;
        mid();
        n_tests++; if (bus.imem_addr !== 16'h0007 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wd_drain_addr: got addr %h req %b expected 0007 1", bus.imem_addr, bus.imem_req); end
        n_tests++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL wd_drain_pc: got %h expected %h", pc, 16'h0100); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL wd_flush_pulse: got %b expected 0", flush); end
        tick();
        bus.imem_ready = 1'b1;
        mid();
        n_tests++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0007) begin n_fail++; $display("FAIL wd_drop: got valid %b addr %h expected 0 0007", bus.instr_valid, bus.imem_addr); end
        tick();
        mid();
        n_tests++; if (bus.imem_addr !== 16'h0100 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL wd_target: got addr %h valid %b expected 0100 1", bus.imem_addr, bus.instr_valid); end
    endtask

    task automatic test_stall();
        tick();
        next_sel = SEL_JREG; jreg_target = 16'h0009;
        mid();
        tick();
        next_sel = SEL_SEQ; stall = 1'b1;
        mid();
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL st_req: got %b expected 0", bus.imem_req); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin tick(); mid(); end
            n_tests++; if (pc !== 16'h0009 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL st_hold%0d: got pc %h valid %b expected 0009 0", i, pc, bus.instr_valid); end
        end
        tick();
        stall = 1'b0;
        mid();
        n_tests++; if (bus.imem_addr !== 16'h0009 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL st_resume9: got addr %h valid %b expected 0009 1", bus.imem_addr, bus.instr_valid); end
        tick();
        mid();
        n_tests++; if (bus.imem_addr !== 16'h000A || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL st_resume10: got addr %h valid %b expected 000a 1", bus.imem_addr, bus.instr_valid); end
    endtask

    task automatic test_stall_wait();
        tick();
        bus.imem_ready = 1'b0;
        mid();
        tick();
        stall = 1'b1; bus.imem_ready = 1'b1;
        mid();
        n_tests++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h000B) begin n_fail++; $display("FAIL sw_wait: got req %b valid %b addr %h expected 1 0 000b", bus.imem_req, bus.instr_valid, bus.imem_addr); end
        tick();
        mid();
        n_tests++; if (bus.imem_req !== 1'b0 || pc !== 16'h000B) begin n_fail++; $display("FAIL sw_frozen: got req %b pc %h expected 0 000b", bus.imem_req, pc); end
        tick();
        stall = 1'b0;
        mid();
        n_tests++; if (bus.imem_addr !== 16'h000B || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL sw_refetch: got addr %h valid %b expected 000b 1", bus.imem_addr, bus.instr_valid); end
    endtask

    task automatic test_halt();
        tick();
        next_sel = SEL_JMP; jump_target = 16'h0020;
        mid();
        tick();
        next_sel = SEL_SEQ; halt = 1'b1;
        mid();
        n_tests++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL ht_cycle: got req %b valid %b expected 0 0", bus.imem_req, bus.instr_valid); end
        tick();
        halt = 1'b0;
        mid();
        n_tests++; if (halted !== 1'b1 || bus.imem_req !== 1'b0 || pc !== 16'h0020) begin n_fail++; $display("FAIL ht_halted: got halted %b req %b pc %h expected 1 0 0020", halted, bus.imem_req, pc); end
        tick();
        resume = 1'b1;
        mid();
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ht_resume_cycle: got %b expected 1", halted); end
        tick();
        resume = 1'b0;
        mid();
        n_tests++; if (halted !== 1'b0 || bus.imem_addr !== 16'h0020 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL ht_refetch: got halted %b addr %h valid %b expected 0 0020 1", halted, bus.imem_addr, bus.instr_valid); end
    endtask

    task automatic test_wrap();
        tick();
        next_sel = SEL_JMP; jump_target = 16'hFFFF;
        mid();
        tick();
        next_sel = SEL_SEQ;
        mid();
        n_tests++; if (bus.imem_addr !== 16'hFFFF || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_top: got addr %h valid %b expected ffff 1", bus.imem_addr, bus.instr_valid); end
        tick();
        mid();
        n_tests++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", bus.imem_addr); end
    endtask

    task automatic test_async_reset();
        tick();
        bus.imem_ready = 1'b0;
        mid();
        tick();
        mid();
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0001) begin n_fail++; $display("FAIL ar_wait: got req %b addr %h expected 1 0001", bus.imem_req, bus.imem_addr); end
        #1 rst = 1'b1;
        #1;
        n_tests++; if (pc !== 16'h0000 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_async: got pc %h req %b expected 0000 0", pc, bus.imem_req); end
        tick();
        rst = 1'b0; bus.imem_ready = 1'b1;
        mid();
        n_tests++; if (bus.imem_req !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL ar_boot: got req %b halted %b expected 0 0", bus.imem_req, halted); end
    endtask

`ifdef PC_SEQ_PERF_EN
    task automatic test_perf();
        n_tests++; if (redirect_cnt !== 32'd0 || stall_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_clear: got %0d %0d expected 0 0", redirect_cnt, stall_cnt); end
        tick(); mid();
        for (int k = 0; k < 3; k++) begin
            tick();
            next_sel = SEL_JMP; jump_target = 16'h0050 + 16'(k);
            mid();
        end
        tick();
        next_sel = SEL_SEQ; stall = 1'b1;
        for (int k = 0; k < 4; k++) begin mid(); tick(); end
        mid();
        tick();
        stall = 1'b0;
        mid();
        n_tests++; if (redirect_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_redirect: got %0d expected 3", redirect_cnt); end
        n_tests++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_stall: got %0d expected 5", stall_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_wait_drain();
        test_stall();
        test_stall_wait();
        test_halt();
        test_wrap();
        test_async_reset();
`ifdef PC_SEQ_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
